data_memory_lsu: RTL and testbench

//  Byte-addressed, little-endian data memory with a valid/ready request/response interface.

---
 rtl/mem_pkg.sv | 35 +++
 rtl/mem_load_align.sv | 31 +++
 rtl/data_memory_lsu.sv | 111 +++++++++++
 tb/tb_data_memory_lsu.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for the data memory load/store path.
// Covers funct3 size decoding and the request/response FSM states.
package mem_pkg;

    typedef enum logic [2:0] {
        MEM_B  = 3'b000,
        MEM_H  = 3'b001,
        MEM_W  = 3'b010,
        MEM_D  = 3'b011,
        MEM_BU = 3'b100,
        MEM_HU = 3'b101,
        MEM_WU = 3'b110
    } mem_size_e;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RESP = 1'b1
    } lsu_state_e;

    function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
        logic [3:0] s;
        unique case (funct3[1:0])
            2'b00:   s = 4'd1;
            2'b01:   s = 4'd2;
            2'b10:   s = 4'd4;
            default: s = 4'd8;
        endcase
        return s;
    endfunction

    function automatic logic is_unsigned(input logic [2:0] funct3);
        return funct3[2];
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Extends the eight raw little-endian load bytes to an XLEN result.
// Sign or zero extension follows the funct3 encoding.
module mem_load_align
    import mem_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [63:0]     raw,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] data
);

    mem_size_e  kind;
    logic       sx;
    logic [63:0] ext;

    always_comb begin
        kind = mem_size_e'(funct3);
        sx   = !is_unsigned(funct3);
        ext  = raw;
        unique case (kind)
            MEM_B, MEM_BU: ext = {{56{sx & raw[7]}}, raw[7:0]};
            MEM_H, MEM_HU: ext = {{48{sx & raw[15]}}, raw[15:0]};
            MEM_W, MEM_WU: ext = {{32{sx & raw[31]}}, raw[31:0]};
            default:       ext = raw;
        endcase
    end

    assign data = ext[XLEN-1:0];

endmodule

// File: rtl/data_memory_lsu.sv
// Byte-addressed little-endian data memory with valid/ready request and
// response channels, one-cycle registered read latency and error flagging.
module data_memory_lsu
    import mem_pkg::*;
#(
    parameter int XLEN        = 64,
    parameter int DEPTH_BYTES = 256,
    parameter int ERR_CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [2:0]           req_funct3,
    input  logic [XLEN-1:0]      req_addr,
    input  logic [XLEN-1:0]      req_wdata,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [XLEN-1:0]      resp_rdata,
    output logic                 resp_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int AW = $clog2(DEPTH_BYTES);

    lsu_state_e      state;
    logic            accept;
    logic [3:0]      size;
    logic [XLEN-1:0] size_x;
    logic [XLEN:0]   end_addr;
    logic            misaligned;
    logic            out_of_range;
    logic            illegal;
    logic            req_err;
    logic            do_write;
    logic [AW-1:0]   base;
    logic [63:0]     wdata64;
    logic [63:0]     raw;
    logic [XLEN-1:0] load_data;

    logic [7:0] mem [DEPTH_BYTES-1:0];

    assign resp_valid = (state == RESP);
    assign req_ready  = (state == IDLE) || resp_ready;
    assign accept     = req_valid && req_ready;

    assign size       = size_bytes(req_funct3);
    assign size_x     = XLEN'(size);
    assign misaligned = |(req_addr & (size_x - XLEN'(1)));

    // One extra bit so addresses near the top of the space cannot wrap.
    assign end_addr     = {1'b0, req_addr} + {1'b0, size_x};
    assign out_of_range = end_addr > (XLEN+1)'(DEPTH_BYTES);

    assign illegal = (req_funct3 == 3'b111) ||
                     ((XLEN == 32) &&
                      ((req_funct3 == MEM_D) || (req_funct3 == MEM_WU)));

    assign req_err  = misaligned || out_of_range || illegal;
    assign base     = req_addr[AW-1:0];
    assign wdata64  = 64'(req_wdata);
    assign do_write = reset_n && accept && req_we && !req_err;

    always_comb begin
        raw = '0;
        for (int i = 0; i < 8; i++) begin
            raw[8*i +: 8] = mem[base + AW'(i)];
        end
    end

    mem_load_align #(
        .XLEN(XLEN)
    ) u_align (
        .raw   (raw),
        .funct3(req_funct3),
        .data  (load_data)
    );

    // Storage is deliberately outside the reset domain.
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int i = 0; i < 8; i++) begin
                if (4'(i) < size) begin
                    mem[base + AW'(i)] <= wdata64[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            err_count  <= '0;
        end else begin
            if (accept) begin
                state      <= RESP;
                resp_err   <= req_err;
                resp_rdata <= (req_we || req_err) ? '0 : load_data;
                if (req_err && !(&err_count)) begin
                    err_count <= err_count + ERR_CNT_W'(1);
                end
            end else if (resp_valid && resp_ready) begin
                state <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_data_memory_lsu.sv
// Self-checking bench for data_memory_lsu against a byte-array model.
// Directed scenarios followed by randomized single transactions.
module tb_data_memory_lsu;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic [15:0] err_count;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0]  ref_mem [256];
    logic [15:0] ref_cnt;

    always #5 clk = ~clk;

    data_memory_lsu #(
        .XLEN(64),
        .DEPTH_BYTES(256),
        .ERR_CNT_W(16)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we(req_we),
        .req_funct3(req_funct3),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_rdata(resp_rdata),
        .resp_err(resp_err),
        .err_count(err_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic model_err(input logic [2:0] f3,
                                       input logic [63:0] addr);
        int s;
        s = nbytes(f3);
        if (f3 == 3'b111) return 1'b1;
        if ((addr % 64'(s)) != 0) return 1'b1;
        if (addr > 64'(256 - s)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [63:0] model_load(input logic [2:0] f3,
                                               input logic [63:0] addr);
        int s;
        logic [63:0] v;
        s = nbytes(f3);
        v = 0;
        for (int i = 0; i < s; i++)
            v = v | (64'(ref_mem[int'(addr[7:0]) + i]) << (8 * i));
        if (!f3[2] && s < 8 && v[8*s-1])
            v = v | ~((64'd1 << (8 * s)) - 64'd1);
        return v;
    endfunction

    task automatic model_store(input logic [2:0] f3, input logic [63:0] addr,
                               input logic [63:0] wd);
        for (int i = 0; i < nbytes(f3); i++)
            ref_mem[int'(addr[7:0]) + i] = wd[8*i +: 8];
    endtask

    task automatic xact(input logic we, input logic [2:0] f3,
                        input logic [63:0] addr, input logic [63:0] wd,
                        output logic [63:0] got);
        logic        e;
        logic [63:0] exp;
        int          n;
        e   = model_err(f3, addr);
        exp = 0;
        if (!e && !we) exp = model_load(f3, addr);
        if (!e && we) model_store(f3, addr, wd);
        if (e && ref_cnt != 16'hFFFF) ref_cnt = ref_cnt + 1;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        resp_ready = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", 64'(n < 20), 64'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        got = resp_rdata;
        chk("resp_valid", 64'(resp_valid), 64'd1);
        chk("resp_err", 64'(resp_err), 64'(e));
        chk("resp_rdata", resp_rdata, exp);
        chk("err_count", 64'(err_count), 64'(ref_cnt));
    endtask

    initial begin
        logic [63:0] got;
        logic [63:0] q[$];
        logic [63:0] held;
        logic [63:0] a;
        logic [2:0]  f;

        reset_n    = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = '0;
        req_wdata  = '0;
        resp_ready = 1'b0;
        ref_cnt    = 0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 64'(resp_valid), 64'd0);
        chk("rst_err", 64'(resp_err), 64'd0);
        chk("rst_rdata", resp_rdata, 64'd0);
        chk("rst_cnt", 64'(err_count), 64'd0);
        chk("rst_ready", 64'(req_ready), 64'd1);
        reset_n = 1'b1;

        for (int ad = 0; ad < 256; ad += 8)
            xact(1'b1, 3'b011, 64'(ad), {$urandom, $urandom}, got);

        xact(1'b1, 3'b011, 64'h10, 64'h8877665544332211, got);
        xact(1'b0, 3'b011, 64'h10, 64'h0, got);
        chk("t1_ld", got, 64'h8877665544332211);

        xact(1'b0, 3'b000, 64'h17, 64'h0, got);
        chk("t2_lb", got, 64'hFFFFFFFFFFFFFF88);
        xact(1'b0, 3'b100, 64'h17, 64'h0, got);
        chk("t2_lbu", got, 64'h88);
        xact(1'b0, 3'b001, 64'h16, 64'h0, got);
        chk("t2_lh", got, 64'hFFFFFFFFFFFF8877);
        xact(1'b0, 3'b110, 64'h14, 64'h0, got);
        chk("t2_lwu", got, 64'h88776655);

        xact(1'b1, 3'b010, 64'h22, 64'hDEADBEEFCAFEF00D, got);
        chk("t3_cnt", 64'(err_count), 64'd1);
        xact(1'b0, 3'b011, 64'h20, 64'h0, got);

        xact(1'b0, 3'b011, 64'd252, 64'h0, got);
        xact(1'b0, 3'b000, 64'd255, 64'h0, got);
        xact(1'b0, 3'b011, 64'hFFFFFFFFFFFFFFF8, 64'h0, got);
        xact(1'b0, 3'b111, 64'h0, 64'h0, got);

        // Backpressure: response must hold while resp_ready is low.
        held = model_load(3'b011, 64'h10);
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b011;
        req_addr   = 64'h10;
        resp_ready = 1'b0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("bp_valid", 64'(resp_valid), 64'd1);
            chk("bp_rdata", resp_rdata, held);
            chk("bp_err", 64'(resp_err), 64'd0);
            chk("bp_ready", 64'(req_ready), 64'd0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        chk("bp_drain", 64'(resp_valid), 64'd0);

        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (k > 0) begin
                chk("st_valid", 64'(resp_valid), 64'd1);
                chk("st_ready", 64'(req_ready), 64'd1);
                chk("st_rdata", resp_rdata, q.pop_front());
            end
            a          = 64'h40 + 64'(k / 2);
            req_valid  = 1'b1;
            req_funct3 = 3'b000;
            req_addr   = a;
            if (k % 2 == 0) begin
                req_we    = 1'b1;
                req_wdata = 64'($urandom);
                model_store(3'b000, a, req_wdata);
                q.push_back(64'h0);
            end else begin
                req_we = 1'b0;
                q.push_back(model_load(3'b000, a));
            end
        end
        @(negedge clk);
        chk("st_valid", 64'(resp_valid), 64'd1);
        chk("st_rdata", resp_rdata, q.pop_front());
        req_valid = 1'b0;

        for (int r = 0; r < 200; r++) begin
            f = 3'($urandom_range(0, 7));
            a = 64'($urandom_range(0, 255));
            if ($urandom % 4 != 0) a = a & ~(64'(nbytes(f)) - 64'd1);
            if ($urandom % 16 == 0) a = {$urandom, $urandom};
            xact(1'($urandom % 2), f, a, {$urandom, $urandom}, got);
        end

        // Reset while a response is pending, with a store presented.
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b011;
        req_addr   = 64'h10;
        resp_ready = 1'b0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("r6_pend", 64'(resp_valid), 64'd1);
        reset_n    = 1'b0;
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b011;
        req_addr   = 64'h30;
        req_wdata  = 64'h0123456789ABCDEF;
        resp_ready = 1'b1;
        @(negedge clk);
        chk("r6_valid", 64'(resp_valid), 64'd0);
        chk("r6_cnt", 64'(err_count), 64'd0);
        reset_n   = 1'b1;
        req_valid = 1'b0;
        ref_cnt   = 0;
        xact(1'b0, 3'b011, 64'h30, 64'h0, got);
        xact(1'b0, 3'b011, 64'h10, 64'h0, got);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
